pixel_word_packer: RTL
======================

PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 The module SHALL have parameter BPP, default 3, bytes per pixel; the first byte received is the MSB byte of the pixel (R in bits [23:16] for BPP=3).
REQ-002 The module SHALL have parameter PPW, default 5, pixels per output word.
REQ-003 The module SHALL have parameter WORD_W, default 128, output word width; PPW*BPP*8 <= WORD_W is required, else elaboration error.
REQ-004 The module SHALL have parameter FRAME_PIXELS, default 786432 (1024x768), pixels per frame.
REQ-005 The module SHALL have parameter FIRST_MSB, default 0: 0 = pixel 0 in word bits [BPP*8-1:0]; 1 = pixel 0 in the highest used slot.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The module SHALL have port cpu_resetn, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-008 The module SHALL have port rx_data, input, 8 bits: incoming byte.
REQ-009 The module SHALL have port rx_ready, input, 1 bit: one-cycle strobe; rx_data is valid on that cycle.
REQ-010 The module SHALL have port frame_sync, input, 1 bit: synchronous realign; clears byte, pixel and frame counters, pending word and overflow.
REQ-011 The module SHALL have port word_data, output, WORD_W bits: packed word; unused upper bits are 0.
REQ-012 The module SHALL have port word_valid, output, 1 bit: word_data holds an unconsumed word.
REQ-013 The module SHALL have port word_ready, input, 1 bit: consumer accept; a transfer occurs on a cycle with word_valid && word_ready.
REQ-014 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last word of a frame is loaded into word_data.
REQ-015 The module SHALL have port overflow, output, 1 bit: sticky; set when a byte is dropped.
REQ-016 The module SHALL have port pixel_count, output, clog2(FRAME_PIXELS+1) bits: pixels completed in the current frame.

Function
REQ-017 Each accepted byte SHALL shift into the pixel byte index 0..BPP-1; index BPP-1 completes the pixel and wraps the index to 0.
REQ-018 A completed pixel SHALL be written to assembly slot 0..PPW-1 according to FIRST_MSB, and pixel_count SHALL increment.
REQ-019 The assembly word SHALL be complete when slot PPW-1 is filled or when the pixel is pixel FRAME_PIXELS-1 of the frame; unfilled slots of a partial word SHALL be 0.
REQ-020 Latency: when the output register is empty or is being consumed on that cycle, word_valid SHALL assert on the edge after the rx_ready cycle that completed the word.
REQ-021 When a word completes while the output is occupied and not consumed, the word SHALL be held as pending and loaded on the edge after the consuming cycle.
REQ-022 Any rx_ready while a word is pending SHALL drop the byte, leave all counters unchanged, and set overflow.
REQ-023 word_data and word_valid SHALL remain stable while word_valid && !word_ready.
REQ-024 On the load of a frame's last word: frame_done SHALL pulse, and pixel_count and the slot and byte indices SHALL return to 0 on that same edge.
REQ-025 When frame_sync coincides with rx_ready, frame_sync SHALL win and the byte SHALL be discarded without setting overflow.
REQ-026 frame_sync SHALL NOT clear a word already in the output register; that word remains valid until consumed.
REQ-027 Control SHALL be a state machine with states IDLE (no output), HOLD (output valid), STALL (output valid plus pending).
REQ-028 State transitions SHALL be:
  - IDLE->HOLD on word complete.
  - HOLD->IDLE on consume without a new completion.
  - HOLD->STALL on completion without consume.
  - STALL->HOLD on consume.

Reset
REQ-029 While cpu_resetn=0, all of the following SHALL be 0, asynchronously: word_valid, frame_done, overflow, pixel_count, the indices, pending, and word_data; state SHALL be IDLE.
REQ-030 After cpu_resetn deasserts, the first byte accepted SHALL be byte 0 of pixel 0 of slot 0; a partial word in progress at reset SHALL be lost.

Verification
REQ-031 Bench case, basic word: defaults, word_ready=1, bytes 0x01..0x0F -> one word 0x000D0E0F0A0B0C070809040506010203, word_valid high one cycle after byte 0x0F.
REQ-032 Bench case, FIRST_MSB=1, same 15 bytes -> 0x00010203040506070809 0A0B0C0D0E0F (pixel 0 at bits [119:96]).
REQ-033 Bench case, partial last word: FRAME_PIXELS=7, 21 bytes -> second word has 2 pixels, upper 80 bits 0; frame_done pulses once; pixel_count returns to 0.
REQ-034 Bench case, stall: word_ready=0, 30 bytes -> state STALL; byte 31 dropped and overflow=1; raising word_ready delivers both words in order.
REQ-035 Bench case, frame_sync: frame_sync after 7 bytes -> next 15 bytes form a clean word equal to the basic-word case; a frame_sync coincident with rx_ready drops the byte with overflow=0.
REQ-036 Bench case, reset: cpu_resetn pulsed low mid-word with word_valid=1 -> word_valid=0 immediately, all outputs 0; the next 15 bytes reproduce the basic-word result.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs a byte stream into BPP-byte pixels and PPW-pixel output words with a
// one-deep pending buffer behind the output register; frames may end on a partial word.
//
// state | meaning
// IDLE  | output register empty
// HOLD  | output register holds an unconsumed word
// STALL | output register full and a completed word is pending
module pixel_word_packer #(
   parameter int BPP          = 3,
   parameter int PPW          = 5,
   parameter int WORD_W       = 128,
   parameter int FRAME_PIXELS = 786432,
   parameter int FIRST_MSB    = 0
) (
   input  logic                                    clk,
   input  logic                                    cpu_resetn,
   input  logic [7:0]                              rx_data,
   input  logic                                    rx_ready,
   input  logic                                    frame_sync,
   output logic [WORD_W-1:0]                       word_data,
   output logic                                    word_valid,
   input  logic                                    word_ready,
   output logic                                    frame_done,
   output logic                                    overflow,
   output logic [$clog2(FRAME_PIXELS+1)-1:0]       pixel_count
);
   localparam int PIX_W  = BPP * 8;
   localparam int USED_W = PPW * PIX_W;
   localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
   localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int BIDX_W = (BPP > 1) ? $clog2(BPP) : 1;

   generate
      if (USED_W > WORD_W) begin : g_bad_cfg
         $error("pixel_word_packer: PPW*BPP*8 exceeds WORD_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [BIDX_W-1:0]   r_byte_idx;
   logic [PIX_W-1:0]    r_pix_shift;
   logic [SLOT_W-1:0]   r_slot_idx;
   logic [USED_W-1:0]   r_asm;
   logic [CNT_W-1:0]    r_pix_cnt;
   logic [USED_W-1:0]   r_pend_word;
   logic                r_pend_last;
   logic [WORD_W-1:0]   r_word_data;
   logic                r_frame_done;
   logic                r_overflow;

   logic                w_consume;
   logic                w_accept;
   logic                w_drop;
   logic                w_pix_done;
   logic                w_last_pix;
   logic                w_word_done;
   logic                w_load_new;
   logic                w_load_pend;
   logic                w_to_pend;
   logic [PIX_W-1:0]    w_pix_val;
   logic [SLOT_W-1:0]   w_slot_pos;
   logic [USED_W-1:0]   w_asm_next;

   // A pending word blocks all byte intake; frame_sync swallows a coincident byte silently.
   assign w_consume   = (r_state != S_IDLE) && word_ready;
   assign w_accept    = rx_ready && !frame_sync && (r_state != S_STALL);
   assign w_drop      = rx_ready && !frame_sync && (r_state == S_STALL);
   assign w_pix_done  = w_accept && (r_byte_idx == BIDX_W'(BPP - 1));
   assign w_last_pix  = (r_pix_cnt == CNT_W'(FRAME_PIXELS - 1));
   assign w_word_done = w_pix_done && ((r_slot_idx == SLOT_W'(PPW - 1)) || w_last_pix);
   assign w_pix_val   = PIX_W'({r_pix_shift, rx_data});
   assign w_slot_pos  = (FIRST_MSB != 0) ? (SLOT_W'(PPW - 1) - r_slot_idx) : r_slot_idx;

   always_comb begin
      w_asm_next = r_asm;
      for (int s = 0; s < PPW; s++) begin
         if (w_slot_pos == SLOT_W'(s)) begin
            w_asm_next[s*PIX_W +: PIX_W] = w_pix_val;
         end
      end
   end

   always_ff @(posedge clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_word_done) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (w_word_done && !w_consume)      w_state_nxt = S_STALL;
            else if (w_consume && !w_word_done) w_state_nxt = S_IDLE;
         end
         S_STALL: begin
            if (frame_sync)     w_state_nxt = w_consume ? S_IDLE : S_HOLD;
            else if (w_consume) w_state_nxt = S_HOLD;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      word_valid  = (r_state != S_IDLE);
      w_load_new  = 1'b0;
      w_load_pend = 1'b0;
      w_to_pend   = 1'b0;
      case (r_state)
         S_IDLE:  w_load_new  = w_word_done;
         S_HOLD: begin
            w_load_new = w_word_done && w_consume;
            w_to_pend  = w_word_done && !w_consume;
         end
         S_STALL: w_load_pend = w_consume && !frame_sync;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         r_byte_idx   <= '0;
         r_pix_shift  <= '0;
         r_slot_idx   <= '0;
         r_asm        <= '0;
         r_pix_cnt    <= '0;
         r_pend_word  <= '0;
         r_pend_last  <= 1'b0;
         r_word_data  <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (frame_sync) begin
            r_byte_idx  <= '0;
            r_slot_idx  <= '0;
            r_asm       <= '0;
            r_pix_cnt   <= '0;
            r_pend_word <= '0;
            r_pend_last <= 1'b0;
            r_overflow  <= 1'b0;
         end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_accept) begin
               r_pix_shift <= w_pix_val;
               r_byte_idx  <= w_pix_done ? '0 : r_byte_idx + BIDX_W'(1);
            end
            if (w_pix_done) begin
               if (w_word_done) begin
                  r_asm      <= '0;
                  r_slot_idx <= '0;
               end else begin
                  r_asm      <= w_asm_next;
                  r_slot_idx <= r_slot_idx + SLOT_W'(1);
               end
               // A frame's last word parked as pending keeps the count at FRAME_PIXELS until loaded.
               r_pix_cnt <= (w_last_pix && w_load_new) ? '0 : r_pix_cnt + CNT_W'(1);
            end
            if (w_to_pend) begin
               r_pend_word <= w_asm_next;
               r_pend_last <= w_last_pix;
            end
            if (w_load_new) begin
               r_word_data  <= WORD_W'(w_asm_next);
               r_frame_done <= w_last_pix;
            end else if (w_load_pend) begin
               r_word_data  <= WORD_W'(r_pend_word);
               r_frame_done <= r_pend_last;
               r_pend_last  <= 1'b0;
               if (r_pend_last) r_pix_cnt <= '0;
            end
         end
      end
   end

   assign word_data   = r_word_data;
   assign frame_done  = r_frame_done;
   assign overflow    = r_overflow;
   assign pixel_count = r_pix_cnt;

endmodule
